// File: rtl/hzd_pkg.sv
// Shared definitions for the pipeline hazard controller: one-hot opcode bit positions,
// forwarding-source codes and the scoreboard entry layout.
package hzd_pkg;

  localparam int OPC_STORE  = 2;
  localparam int OPC_LOAD   = 3;
  localparam int OPC_MOVE   = 4;
  localparam int OPC_RR_LO  = 5;   // reg-reg ALU group occupies bits 13:5
  localparam int OPC_RR_HI  = 13;
  localparam int OPC_NOT    = 14;
  localparam int OPC_MOVEI  = 15;
  localparam int OPC_SLI    = 16;
  localparam int OPC_SRI    = 17;
  localparam int OPC_ADDI   = 18;
  localparam int OPC_SUBI   = 19;
  localparam int OPC_JUMP   = 20;
  localparam int OPC_BRANCH = 21;
  localparam int OPC_FADD   = 22;
  localparam int OPC_FMULT  = 23;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_DM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;

  localparam int SB_EX    = 0;
  localparam int SB_DM    = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;
  localparam int SB_RD_W  = 8;     // widest register address the scoreboard can hold

  typedef struct packed {
    logic               v;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/hzd_opc_class.sv
// Combinational classifier: one-hot decoded opcode -> register usage and destination field.
module hzd_opc_class
  import hzd_pkg::*;
#(
  parameter int NREG_W = 5,
  parameter int OPC_W  = 24
) (
  input  logic [OPC_W-1:0]  opc,
  input  logic [NREG_W-1:0] rs2,
  input  logic [NREG_W-1:0] rd,
  output logic              writes_rd,
  output logic              uses_rs1,
  output logic              uses_rs2,
  output logic              is_load,
  output logic [NREG_W-1:0] dest
);

  logic any_op;
  logic rs2_is_dest;

  // immediate-form and load/move ops carry their destination in the rs2 field
  always_comb begin
    any_op      = |opc;
    rs2_is_dest = opc[OPC_LOAD] | opc[OPC_MOVE] | opc[OPC_NOT] | opc[OPC_MOVEI] |
                  opc[OPC_SLI]  | opc[OPC_SRI]  | opc[OPC_ADDI] | opc[OPC_SUBI];
    dest        = rs2_is_dest ? rs2 : rd;
    writes_rd   = any_op & ~(opc[OPC_STORE] | opc[OPC_JUMP] | opc[OPC_BRANCH]);
    uses_rs1    = any_op & ~(opc[OPC_MOVEI] | opc[OPC_JUMP]);
    uses_rs2    = (|opc[OPC_RR_HI:OPC_RR_LO]) | opc[OPC_STORE] | opc[OPC_FADD] | opc[OPC_FMULT];
    is_load     = opc[OPC_LOAD];
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW-hazard stall and branch/jump flush controller beside the RF stage.
// Define HZD_FORWARD_EN to enable operand forwarding (only load-use then stalls).
module pipeline_hazard_ctrl
  import hzd_pkg::*;
#(
  parameter int NREG_W  = 5,
  parameter int OPC_W   = 24,
  parameter int CNT_W   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  id_opc,
  input  logic [NREG_W-1:0] id_rs1,
  input  logic [NREG_W-1:0] id_rs2,
  input  logic [NREG_W-1:0] id_rd,
  input  logic              id_br_eq,
  output logic              pc_hold,
  output logic              ir_hold,
  output logic              ir_flush,
  output logic              alu_bubble,
  output logic              pc_redirect,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t             sb [SB_DEPTH];
  logic                  id_valid_q;
  logic                  writes_rd, uses_rs1, uses_rs2, is_load;
  logic [NREG_W-1:0]     dest;
  logic [SB_DEPTH-1:0]   hit_a, hit_b;
  logic                  load_use, stall, redirect;
  logic [1:0]            sel_a, sel_b;

  hzd_opc_class #(.NREG_W(NREG_W), .OPC_W(OPC_W)) u_class (
    .opc       (id_opc),
    .rs2       (id_rs2),
    .rd        (id_rd),
    .writes_rd (writes_rd),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .is_load   (is_load),
    .dest      (dest)
  );

  function automatic logic src_hit(input logic use_src, input sb_entry_t e,
                                   input logic [NREG_W-1:0] rs);
    src_hit = use_src & e.v & (e.rd == SB_RD_W'(rs)) & ~((R0_ZERO != 0) & (rs == '0));
  endfunction

`ifdef HZD_FORWARD_EN
  function automatic logic [1:0] pick_src(input logic [SB_DEPTH-1:0] hit);
    if (hit[SB_EX])      pick_src = FWD_EX;
    else if (hit[SB_DM]) pick_src = FWD_DM;
    else if (hit[SB_WB]) pick_src = FWD_WB;
    else                 pick_src = FWD_RF;
  endfunction
`endif

  // hazard detection, forwarding select and pipeline control outputs
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      hit_a[k] = src_hit(uses_rs1, sb[k], id_rs1);
      hit_b[k] = src_hit(uses_rs2, sb[k], id_rs2);
    end
    load_use = sb[SB_EX].is_load & (hit_a[SB_EX] | hit_b[SB_EX]);
`ifdef HZD_FORWARD_EN
    stall = id_valid_q & load_use;
    sel_a = id_valid_q ? pick_src(hit_a) : FWD_RF;
    sel_b = id_valid_q ? pick_src(hit_b) : FWD_RF;
`else
    stall = id_valid_q & (load_use | (|hit_a) | (|hit_b));
    sel_a = FWD_RF;
    sel_b = FWD_RF;
`endif
    redirect = id_valid_q & ~stall & (id_opc[OPC_JUMP] | (id_opc[OPC_BRANCH] & id_br_eq));
    if (reset) begin
      pc_hold     = 1'b0;
      ir_hold     = 1'b0;
      ir_flush    = 1'b1;
      alu_bubble  = 1'b1;
      pc_redirect = 1'b0;
      fwd_sel_a   = FWD_RF;
      fwd_sel_b   = FWD_RF;
    end else begin
      pc_hold     = stall;
      ir_hold     = stall;
      ir_flush    = redirect;
      alu_bubble  = stall;
      pc_redirect = redirect;
      fwd_sel_a   = sel_a;
      fwd_sel_b   = sel_b;
    end
  end

  // scoreboard shift, decode-valid tracking and saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SB_DEPTH; k++) sb[k] <= '0;
      id_valid_q <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      sb[SB_WB]         <= sb[SB_DM];
      sb[SB_DM]         <= sb[SB_EX];
      sb[SB_EX].v       <= id_valid_q & writes_rd & ~stall;
      sb[SB_EX].rd      <= SB_RD_W'(dest);
      sb[SB_EX].is_load <= is_load;
      id_valid_q        <= ~redirect;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      else                            stall_cnt <= stall_cnt;
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      else                               flush_cnt <= flush_cnt;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; expectations follow HZD_FORWARD_EN.
module tb_pipeline_hazard_ctrl;

  localparam int NREG_W = 5;
  localparam int OPC_W  = 24;
  localparam int CNT_W  = 16;
`ifdef HZD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int NS_ADD = FWD ? 0 : 3;
  localparam int NS_NOP = FWD ? 0 : 2;
  localparam int NS_LD  = FWD ? 1 : 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [OPC_W-1:0]  id_opc;
  logic [NREG_W-1:0] id_rs1, id_rs2, id_rd;
  logic              id_br_eq;
  logic              pc_hold, ir_hold, ir_flush, alu_bubble, pc_redirect;
  logic [1:0]        fwd_sel_a, fwd_sel_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_opc(id_opc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_br_eq(id_br_eq), .pc_hold(pc_hold), .ir_hold(ir_hold),
    .ir_flush(ir_flush), .alu_bubble(alu_bubble), .pc_redirect(pc_redirect),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [OPC_W-1:0] oh(input int b);
    logic [OPC_W-1:0] o;
    o    = '0;
    o[b] = 1'b1;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic hold, input logic flush,
                     input logic bubble, input logic redir);
    chk({tag, "/pc_hold"},     32'(pc_hold),     32'(hold));
    chk({tag, "/ir_hold"},     32'(ir_hold),     32'(hold));
    chk({tag, "/ir_flush"},    32'(ir_flush),    32'(flush));
    chk({tag, "/alu_bubble"},  32'(alu_bubble),  32'(bubble));
    chk({tag, "/pc_redirect"}, 32'(pc_redirect), 32'(redir));
  endtask

  task automatic step(input logic rst, input logic [OPC_W-1:0] opc, input int rs1,
                      input int rs2, input int rd, input logic eq);
    @(negedge clk);
    reset    = rst;
    id_opc   = opc;
    id_rs1   = NREG_W'(rs1);
    id_rs2   = NREG_W'(rs2);
    id_rd    = NREG_W'(rd);
    id_br_eq = eq;
    #2;
  endtask

  initial begin
    logic [OPC_W-1:0] nop, addi, add, load, br;
    nop  = '0;
    addi = oh(18);
    add  = oh(5);
    load = oh(3);
    br   = oh(21);

    // reset values
    step(1'b1, nop, 0, 0, 0, 1'b0);
    step(1'b1, nop, 0, 0, 0, 1'b0);
    ctl("rst", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst/stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst/flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst/fwd_a", 32'(fwd_sel_a), 32'd0);
    step(1'b0, nop, 0, 0, 0, 1'b0);
    ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // addi r5 ; add r6,r5,r1 back-to-back
    step(1'b0, addi, 2, 5, 0, 1'b0);
    ctl("addi", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NS_ADD; i++) begin
      step(1'b0, add, 5, 1, 6, 1'b0);
      ctl("raw_ex", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, add, 5, 1, 6, 1'b0);
    ctl("raw_clear", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("raw/fwd_a", 32'(fwd_sel_a), FWD ? 32'd1 : 32'd0);
    chk("raw/fwd_b", 32'(fwd_sel_b), 32'd0);
    chk("raw/stall_cnt", 32'(stall_cnt), 32'(NS_ADD));

    // one NOP between producer r6 and consumer add r9,r6,r2
    step(1'b0, nop, 0, 0, 0, 1'b0);
    for (int i = 0; i < NS_NOP; i++) begin
      step(1'b0, add, 6, 2, 9, 1'b0);
      ctl("raw_dm", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, add, 6, 2, 9, 1'b0);
    ctl("dm_clear", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dm/fwd_a", 32'(fwd_sel_a), FWD ? 32'd2 : 32'd0);
    chk("dm/stall_cnt", 32'(stall_cnt), 32'(NS_ADD + NS_NOP));

    // load r7 ; add r8,r7,r7
    step(1'b0, load, 3, 7, 0, 1'b0);
    ctl("load", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NS_LD; i++) begin
      step(1'b0, add, 7, 7, 8, 1'b0);
      ctl("load_use", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, add, 7, 7, 8, 1'b0);
    ctl("lu_clear", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu/fwd_a", 32'(fwd_sel_a), FWD ? 32'd2 : 32'd0);
    chk("lu/fwd_b", 32'(fwd_sel_b), FWD ? 32'd2 : 32'd0);
    chk("lu/stall_cnt", 32'(stall_cnt), 32'(NS_ADD + NS_NOP + NS_LD));

    // branch not taken, then taken, then the flushed slot
    step(1'b0, br, 4, 0, 0, 1'b0);
    ctl("br_nt", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, br, 4, 0, 0, 1'b1);
    ctl("br_t", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("br_t/flush_cnt", 32'(flush_cnt), 32'd0);
    step(1'b0, br, 4, 0, 0, 1'b1);
    ctl("br_after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_after/id_valid", 32'(dut.id_valid_q), 32'd0);
    chk("br_after/flush_cnt", 32'(flush_cnt), 32'd1);

    // load r10 ; branch on r10 -> stall, then a single redirect
    step(1'b0, load, 0, 10, 0, 1'b0);
    ctl("ld10", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NS_LD; i++) begin
      step(1'b0, br, 10, 0, 0, 1'b1);
      ctl("br_stall", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, br, 10, 0, 0, 1'b1);
    ctl("br_redir", 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, nop, 0, 0, 0, 1'b0);
    ctl("br_slot", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br/flush_cnt", 32'(flush_cnt), 32'd2);
    chk("br/stall_cnt", 32'(stall_cnt), 32'(NS_ADD + NS_NOP + 2 * NS_LD));

    // reset in the middle of a load-use stall
    step(1'b0, load, 0, 11, 0, 1'b0);
    step(1'b0, add, 11, 11, 12, 1'b0);
    ctl("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, add, 11, 11, 12, 1'b0);
    ctl("mid_rst", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mid_rst/fwd_a", 32'(fwd_sel_a), 32'd0);
    chk("mid_rst/fwd_b", 32'(fwd_sel_b), 32'd0);
    step(1'b0, nop, 0, 0, 0, 1'b0);
    ctl("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst/stall_cnt", 32'(stall_cnt), 32'd0);
    chk("post_rst/flush_cnt", 32'(flush_cnt), 32'd0);
    step(1'b0, add, 11, 11, 12, 1'b0);
    ctl("sb_cleared", 1'b0, 1'b0, 1'b0, 1'b0);

    // writes to r0 never create a hazard
    step(1'b0, addi, 2, 0, 0, 1'b0);
    step(1'b0, add, 0, 0, 1, 1'b0);
    ctl("r0", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r0/fwd_a", 32'(fwd_sel_a), 32'd0);
    chk("r0/stall_cnt", 32'(stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
